// File: rtl/txarbiter.sv
// txarbiter: round-robin arbiter that feeds one serial-word transmitter from
// NREQ single-word holding registers. Each channel has its own strobe/busy
// handshake. Held words are forwarded one at a time over the tx stb/busy port.
module txarbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NREQ-1:0]    i_stb,
  input  logic [NREQ*DW-1:0] i_data,
  output logic [NREQ-1:0]    o_busy,
  output logic               o_tx_stb,
  output logic [DW-1:0]      o_tx_data,
  input  logic               i_tx_busy,
  output logic [NREQ-1:0]    o_grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [DW-1:0]   hold_q [NREQ];
  logic [DW-1:0]   hold_d [NREQ];
  logic [PW-1:0]   last_q, last_d;
  logic            tx_stb_q, tx_stb_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic [NREQ-1:0] grant_q, grant_d;

  logic            found;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   idx;
  logic            issue;

  // Round-robin search: walk last+1 .. last with an explicit wrap so that
  // non-power-of-2 channel counts never index past NREQ-1.
  always_comb begin
    found = 1'b0;
    sel   = last_q;
    idx   = last_q;
    for (int i = 0; i < NREQ; i++) begin
      idx = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Issue/accept FSM: launch the selected word from IDLE, hold it in SEND
  // until the transmitter stops signalling busy.
  always_comb begin
    state_d   = state_q;
    tx_stb_d  = tx_stb_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !i_tx_busy) begin
          issue        = 1'b1;
          tx_stb_d     = 1'b1;
          tx_data_d    = hold_q[sel];
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          last_d       = sel;
          state_d      = SEND;
        end
      end
      SEND: begin
        // Grant and data deliberately keep their values after acceptance.
        if (!i_tx_busy) begin
          tx_stb_d = 1'b0;
          state_d  = IDLE;
        end
      end
    endcase
  end

  // Channel holding registers: capture on strobe when free, free on selection.
  // A strobe on a channel that is still pending (including the cycle it is
  // selected) is silently dropped.
  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    for (int k = 0; k < NREQ; k++) begin
      if (i_stb[k] && !pend_q[k]) begin
        pend_d[k] = 1'b1;
        hold_d[k] = i_data[k*DW +: DW];
      end
    end
    if (issue) pend_d[sel] = 1'b0;
  end

  // State registers; reset drops any word in flight and gives channel 0 top
  // priority by parking the pointer on the last channel.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      last_q    <= PW'(NREQ - 1);
      tx_stb_q  <= 1'b0;
      tx_data_q <= '0;
      grant_q   <= '0;
      for (int k = 0; k < NREQ; k++) hold_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      last_q    <= last_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      for (int k = 0; k < NREQ; k++) hold_q[k] <= hold_d[k];
    end
  end

  assign o_busy    = pend_q;
  assign o_tx_stb  = tx_stb_q;
  assign o_tx_data = tx_data_q;
  assign o_grant   = grant_q;

endmodule

// File: tb/tb_txarbiter.sv
// tb_txarbiter: directed stimulus with a behavioural arbiter model checked
// every cycle, plus literal expectations for each scenario.
module tb_txarbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic               i_clk = 1'b0;
  logic               i_reset_n;
  logic [NREQ-1:0]    i_stb;
  logic [NREQ*DW-1:0] i_data;
  logic [NREQ-1:0]    o_busy;
  logic               o_tx_stb;
  logic [DW-1:0]      o_tx_data;
  logic               i_tx_busy;
  logic [NREQ-1:0]    o_grant;

  txarbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stb(i_stb), .i_data(i_data),
    .o_busy(o_busy), .o_tx_stb(o_tx_stb), .o_tx_data(o_tx_data),
    .i_tx_busy(i_tx_busy), .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [NREQ-1:0] m_pend;
  logic [DW-1:0]   m_hold [NREQ];
  int              m_last;
  logic            m_stb;
  logic [DW-1:0]   m_data;
  logic [NREQ-1:0] m_grant;

  // transmitter emulation and acceptance log
  logic            auto_busy;
  int              bcnt;
  logic [DW-1:0]   acc_data[$];
  logic [NREQ-1:0] acc_grant[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    for (int k = 0; k < NREQ; k++) m_hold[k] = '0;
    m_last  = NREQ - 1;
    m_stb   = 1'b0;
    m_data  = '0;
    m_grant = '0;
  endtask

  // One clock: log acceptance, advance model, emulate transmitter busy.
  task automatic step();
    logic            accept_now;
    logic [NREQ-1:0] n_pend;
    logic [DW-1:0]   n_hold [NREQ];
    logic            n_stb;
    logic [DW-1:0]   n_data;
    logic [NREQ-1:0] n_grant;
    int              n_last;
    int              c;
    accept_now = o_tx_stb && !i_tx_busy && i_reset_n;
    if (accept_now) begin
      acc_data.push_back(o_tx_data);
      acc_grant.push_back(o_grant);
    end
    n_pend = m_pend; n_stb = m_stb; n_data = m_data; n_grant = m_grant; n_last = m_last;
    for (int k = 0; k < NREQ; k++) n_hold[k] = m_hold[k];
    if (!i_tx_busy) begin
      if (m_stb) n_stb = 1'b0;
      else begin
        for (int j = 1; j <= NREQ; j++) begin
          c = (m_last + j) % NREQ;
          if (m_pend[c]) begin
            n_stb = 1'b1; n_data = m_hold[c];
            n_grant = '0; n_grant[c] = 1'b1;
            n_last = c; n_pend[c] = 1'b0;
            break;
          end
        end
      end
    end
    for (int k = 0; k < NREQ; k++)
      if (i_stb[k] && !m_pend[k]) begin
        n_pend[k] = 1'b1;
        n_hold[k] = i_data[k*DW +: DW];
      end
    @(posedge i_clk);
    #1;
    if (i_reset_n) begin
      m_pend = n_pend; m_stb = n_stb; m_data = n_data; m_grant = n_grant; m_last = n_last;
      for (int k = 0; k < NREQ; k++) m_hold[k] = n_hold[k];
    end
    if (auto_busy) begin
      if (accept_now) bcnt = 10;
      else if (bcnt > 0) bcnt--;
      i_tx_busy = (bcnt > 0);
    end
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_stb = '0;
    #1;
    model_reset();
    repeat (2) step();
    i_reset_n = 1'b1;
  endtask

  task automatic clear_log();
    acc_data.delete();
    acc_grant.delete();
  endtask

  // Per-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (i_reset_n === 1'b1) begin
      check("cyc tx_stb", 64'(o_tx_stb), 64'(m_stb));
      check("cyc tx_data", 64'(o_tx_data), 64'(m_data));
      check("cyc grant", 64'(o_grant), 64'(m_grant));
      check("cyc busy", 64'(o_busy), 64'(m_pend));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n = 1'b0; i_stb = '0; i_data = '0; i_tx_busy = 1'b0;
    auto_busy = 1'b0; bcnt = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("rst tx_stb", 64'(o_tx_stb), 64'd0);
    check("rst tx_data", 64'(o_tx_data), 64'd0);
    check("rst grant", 64'(o_grant), 64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    i_reset_n = 1'b1;
    step();

    // Single word on channel 2
    i_stb = 4'b0100;
    i_data[2*DW +: DW] = 32'hDEADBEEF;
    step();
    i_stb = '0;
    check("single busy2", 64'(o_busy[2]), 64'd1);
    check("single stb early", 64'(o_tx_stb), 64'd0);
    step();
    check("single stb", 64'(o_tx_stb), 64'd1);
    check("single data", 64'(o_tx_data), 64'hDEADBEEF);
    check("single grant", 64'(o_grant), 64'b0100);
    step();
    check("single stb drop", 64'(o_tx_stb), 64'd0);
    check("single grant kept", 64'(o_grant), 64'b0100);

    // Simultaneous load with a 10-cycle busy transmitter
    do_reset();
    clear_log();
    auto_busy = 1'b1;
    i_stb = 4'b1111;
    for (int k = 0; k < NREQ; k++) i_data[k*DW +: DW] = 32'h10 + k;
    step();
    i_stb = '0;
    for (int t = 0; t < 200 && acc_data.size() < 4; t++) step();
    check("load count", 64'(acc_data.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < acc_data.size()) begin
        check("load data", 64'(acc_data[k]), 64'h10 + k);
        check("load grant", 64'(acc_grant[k]), 64'd1 << k);
      end
    for (int t = 0; t < 20 && bcnt > 0; t++) step();
    auto_busy = 1'b0;
    i_tx_busy = 1'b0;
    step();

    // Fairness: after a grant to channel 1, channel 3 beats channel 0
    do_reset();
    clear_log();
    i_stb = 4'b0010;
    i_data[1*DW +: DW] = 32'h21;
    step();
    i_stb = '0;
    repeat (4) step();
    check("fair first grant", 64'(acc_grant.size() > 0 ? acc_grant[0] : 4'b0), 64'b0010);
    i_tx_busy = 1'b1;
    i_stb = 4'b1001;
    i_data[0*DW +: DW] = 32'h30;
    i_data[3*DW +: DW] = 32'h33;
    step();
    i_stb = '0;
    step();
    i_tx_busy = 1'b0;
    clear_log();
    for (int t = 0; t < 20 && acc_data.size() < 2; t++) step();
    check("fair count", 64'(acc_data.size()), 64'd2);
    if (acc_data.size() == 2) begin
      check("fair grant a", 64'(acc_grant[0]), 64'b1000);
      check("fair data a", 64'(acc_data[0]), 64'h33);
      check("fair grant b", 64'(acc_grant[1]), 64'b0001);
      check("fair data b", 64'(acc_data[1]), 64'h30);
    end
    repeat (2) step();

    // Backpressure: 20 cycles of transmitter busy on channel 1's word
    clear_log();
    i_stb = 4'b0010;
    i_data[1*DW +: DW] = 32'h11112222;
    step();
    i_stb = '0;
    step();
    check("bp stb up", 64'(o_tx_stb), 64'd1);
    i_tx_busy = 1'b1;
    for (int t = 0; t < 20; t++) begin
      step();
      check("bp stb held", 64'(o_tx_stb), 64'd1);
      check("bp data held", 64'(o_tx_data), 64'h11112222);
    end
    check("bp no accept", 64'(acc_data.size()), 64'd0);
    i_tx_busy = 1'b0;
    step();
    check("bp one accept", 64'(acc_data.size()), 64'd1);
    check("bp stb drop", 64'(o_tx_stb), 64'd0);
    step();

    // Writes to a busy channel are dropped
    clear_log();
    i_tx_busy = 1'b1;
    i_stb = 4'b0001;
    i_data[0*DW +: DW] = 32'hAAAA;
    step();
    check("drop busy0", 64'(o_busy[0]), 64'd1);
    i_data[0*DW +: DW] = 32'hBBBB;
    step();
    i_stb = '0;
    check("drop busy0 still", 64'(o_busy[0]), 64'd1);
    i_tx_busy = 1'b0;
    repeat (8) step();
    check("drop count", 64'(acc_data.size()), 64'd1);
    if (acc_data.size() > 0) check("drop data", 64'(acc_data[0]), 64'hAAAA);

    // Asynchronous reset mid-SEND with two channels pending
    clear_log();
    i_stb = 4'b0001;
    i_data[0*DW +: DW] = 32'h77;
    step();
    i_stb = '0;
    step();
    check("mid stb up", 64'(o_tx_stb), 64'd1);
    i_tx_busy = 1'b1;
    i_stb = 4'b1100;
    i_data[2*DW +: DW] = 32'h52;
    i_data[3*DW +: DW] = 32'h53;
    step();
    i_stb = '0;
    check("mid pend", 64'(o_busy), 64'b1100);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("arst stb", 64'(o_tx_stb), 64'd0);
    check("arst busy", 64'(o_busy), 64'd0);
    check("arst grant", 64'(o_grant), 64'd0);
    model_reset();
    repeat (2) step();
    i_reset_n = 1'b1;
    i_tx_busy = 1'b0;
    clear_log();
    repeat (10) step();
    check("post rst idle", 64'(acc_data.size()), 64'd0);
    check("post rst stb", 64'(o_tx_stb), 64'd0);
    i_stb = 4'b1000;
    i_data[3*DW +: DW] = 32'h99;
    step();
    i_stb = '0;
    step();
    check("post rst new stb", 64'(o_tx_stb), 64'd1);
    check("post rst new data", 64'(o_tx_data), 64'h99);
    check("post rst new grant", 64'(o_grant), 64'b1000);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
